// File: rtl/quarter_wave_dds.sv
// Quarter-wave DDS: phase accumulator folded onto an external quarter-table ROM.
// Define SIGNED_OUT_EN for two's-complement samples; the default build emits offset binary.
module quarter_wave_dds #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_ld,
    input  logic [PHASE_W-1:0] phase_val,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-2:0]  rom_data,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic [1:0]         quadrant
);

    localparam int unsigned MAG_W = DATA_W - 1;
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << MAG_W;
`ifdef SIGNED_OUT_EN
    localparam logic [DATA_W-1:0] RST_SAMPLE = '0;
`else
    localparam logic [DATA_W-1:0] RST_SAMPLE = MID;
`endif

    logic [PHASE_W-1:0] acc;
    logic [1:0]         q;
    logic [ADDR_W-1:0]  idx;
    logic [1:0]         q1;
    logic               s1;
    logic [DATA_W-1:0]  mag_ext;
    logic [DATA_W-1:0]  sample_nxt;

    // Phase accumulator; a load overrides the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (phase_ld) begin
            acc <= phase_val;
        end else if (en) begin
            acc <= acc + phase_inc;
        end
    end

    assign q   = acc[PHASE_W-1 -: 2];
    assign idx = acc[PHASE_W-3 -: ADDR_W];

    // Odd quadrants walk the table backwards; ~idx equals 2^ADDR_W-1-idx.
    assign rom_addr = q[0] ? ~idx : idx;

    // Stage 1 tracks the quadrant and slot validity alongside the ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= 2'd0;
            s1 <= 1'b0;
        end else begin
            q1 <= q;
            s1 <= en;
        end
    end

    // Second half-period takes the negated magnitude.
    always_comb begin
        mag_ext = DATA_W'(rom_data);
`ifdef SIGNED_OUT_EN
        sample_nxt = q1[1] ? (DATA_W'(0) - mag_ext) : mag_ext;
`else
        sample_nxt = q1[1] ? (MID - mag_ext) : (MID + mag_ext);
`endif
    end

    // Stage 2 output register; holds when the slot is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample       <= RST_SAMPLE;
            quadrant     <= 2'd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= s1;
            if (s1) begin
                sample   <= sample_nxt;
                quadrant <= q1;
            end
        end
    end

endmodule

// File: tb/tb_quarter_wave_dds.sv
// Scoreboard bench for quarter_wave_dds with a ramp ROM (rom_data = address).
module tb_quarter_wave_dds;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned PHASE_W = 16;
`ifdef SIGNED_OUT_EN
    localparam logic [7:0] RST_S = 8'h00;
`else
    localparam logic [7:0] RST_S = 8'h80;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic [1:0] q;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [PHASE_W-1:0] phase_inc = '0;
    logic               phase_ld = 1'b0;
    logic [PHASE_W-1:0] phase_val = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-2:0]  rom_data = '0;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic [1:0]         quadrant;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];
    logic [15:0] m_acc = '0;
    logic [6:0]  exp_addr = '0;
    logic [7:0]  last_s = RST_S;
    logic [1:0]  last_q = 2'd0;

    quarter_wave_dds #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .rst(rst), .en(en), .phase_inc(phase_inc), .phase_ld(phase_ld),
        .phase_val(phase_val), .rom_addr(rom_addr), .rom_data(rom_data),
        .sample(sample), .sample_valid(sample_valid), .quadrant(quadrant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= 7'(rom_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [6:0] addr_of(input logic [15:0] a);
        logic [6:0] i;
        i = a[13:7];
        return a[14] ? 7'(7'd127 - i) : i;
    endfunction

    function automatic exp_t exp_of(input logic [15:0] a);
        exp_t e;
        logic [7:0] mag;
        mag = {1'b0, addr_of(a)};
        e.q = a[15:14];
`ifdef SIGNED_OUT_EN
        e.s = a[15] ? 8'(8'd0 - mag) : mag;
`else
        e.s = a[15] ? 8'(8'd128 - mag) : 8'(8'd128 + mag);
`endif
        return e;
    endfunction

    // Drive one cycle, record the expected sample, advance the phase model.
    task automatic step(input logic r, input logic ld, input logic [15:0] val,
                        input logic e, input logic [15:0] inc);
        @(negedge clk);
        rst = r; phase_ld = ld; phase_val = val; en = e; phase_inc = inc;
        if (r) begin
            sb.delete();
            m_acc = '0;
        end else begin
            if (e) sb.push_back(exp_of(m_acc));
            if (ld) m_acc = val;
            else if (e) m_acc = m_acc + inc;
        end
        exp_addr = addr_of(m_acc);
        @(posedge clk);
        #1;
    endtask

    // Monitor: address every cycle, reset values, scoreboard pops, hold when idle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
            if (rst) begin
                chk("rst_valid", 32'(sample_valid), 32'd0);
                chk("rst_sample", 32'(sample), 32'(RST_S));
                chk("rst_quadrant", 32'(quadrant), 32'd0);
                last_s = RST_S;
                last_q = 2'd0;
            end else if (sample_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got sample 0x%0h, want no valid at %0t", sample, $time);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("sample", 32'(sample), 32'(x.s));
                    chk("quadrant", 32'(quadrant), 32'(x.q));
                    last_s = x.s;
                    last_q = x.q;
                end
            end else begin
                chk("hold_sample", 32'(sample), 32'(last_s));
                chk("hold_quadrant", 32'(quadrant), 32'(last_q));
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("reset_sample", 32'(sample), 32'(RST_S));
        chk("reset_valid", 32'(sample_valid), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_quadrant", 32'(quadrant), 32'd0);

        // Full period plus a little, one table step per clock.
        repeat (520) step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);

        // Five-cycle gap: valid lags en by one edge.
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0080);
        chk("gap_lag", 32'(sample_valid), 32'd1);
        repeat (4) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0080);
            chk("gap_low", 32'(sample_valid), 32'd0);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);
        chk("gap_low", 32'(sample_valid), 32'd0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);
        chk("gap_resume", 32'(sample_valid), 32'd1);
        repeat (20) step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);

        // Load with en low: accumulator moves, no slot issued.
        step(1'b0, 1'b1, 16'h2000, 1'b0, 16'h0);
        chk("load_idle_addr", 32'(rom_addr), 32'h40);

        // Latency: load 0x4000, peak appears two edges later.
        step(1'b0, 1'b1, 16'h4000, 1'b1, 16'h0);
        chk("lat_addr", 32'(rom_addr), 32'd127);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
`ifdef SIGNED_OUT_EN
        chk("lat_sample", 32'(sample), 32'h7F);
`else
        chk("lat_sample", 32'(sample), 32'hFF);
`endif
        chk("lat_quadrant", 32'(quadrant), 32'd1);

        // Wrap through zero phase.
        step(1'b0, 1'b1, 16'hFFC0, 1'b1, 16'h0080);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);
        chk("wrap_sample_q3", 32'(sample), 32'(RST_S));
        chk("wrap_quadrant_q3", 32'(quadrant), 32'd3);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);
        chk("wrap_sample_q0", 32'(sample), 32'(RST_S));
        chk("wrap_quadrant_q0", 32'(quadrant), 32'd0);

        // Quadrant-3 trough at phase 0xC000.
        step(1'b0, 1'b1, 16'hC000, 1'b1, 16'h0);
        chk("trough_addr", 32'(rom_addr), 32'd127);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
`ifdef SIGNED_OUT_EN
        chk("trough_sample", 32'(sample), 32'h81);
`else
        chk("trough_sample", 32'(sample), 32'h01);
`endif
        chk("trough_quadrant", 32'(quadrant), 32'd3);

        // Reset mid-stream discards in-flight samples.
        repeat (5) step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0080);
        step(1'b1, 1'b0, 16'h0, 1'b1, 16'h0080);
        chk("midrst_valid", 32'(sample_valid), 32'd0);
        chk("midrst_sample", 32'(sample), 32'(RST_S));
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0100);

        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
